// File: rtl/sdmac_pkg.sv
// Shared constants and types for the SDMAC output-side longword FIFO.
package sdmac_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    // Byte lanes of a 32-bit entry; lane 3 is the most significant byte.
    localparam int LANE0_MSB = 7;
    localparam int LANE1_MSB = 15;
    localparam int LANE2_MSB = 23;
    localparam int LANE3_MSB = 31;

    typedef enum logic [1:0] {
        CMT_NONE,
        CMT_BYTE,
        CMT_LONG,
        CMT_FLUSH
    } commit_src_e;

    // Byte offset 0 lands in the most significant lane (big-endian packing).
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        case (offset)
            2'd0:    result[LANE3_MSB -: 8] = data;
            2'd1:    result[LANE2_MSB -: 8] = data;
            2'd2:    result[LANE1_MSB -: 8] = data;
            default: result[LANE0_MSB -: 8] = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sdmac_byte_packer.sv
// Packs SCSI-side bytes into a longword staging register and arbitrates
// between byte, longword and flush commits towards the FIFO.
module sdmac_byte_packer
    import sdmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_byte,
    input  logic [7:0]  byte_data,
    input  logic        wr_long,
    input  logic [31:0] long_data,
    input  logic        flush,
    output logic [1:0]  bo,
    output logic        err,
    output logic        commit_valid,
    output logic [31:0] commit_data
);

    logic [31:0] staging;
    logic        byte_en;
    logic [31:0] packed_word;
    logic [1:0]  bo_next;
    commit_src_e src;

    // Byte steering and commit-source selection; a longword write masks any byte write.
    always_comb begin
        byte_en     = wr_byte && !wr_long;
        packed_word = byte_en ? lane_insert(staging, bo, byte_data) : staging;
        bo_next     = byte_en ? bo + 2'd1 : bo;
        src         = CMT_NONE;
        if (wr_long && bo == 2'd0) begin
            src = CMT_LONG;
        end else if (byte_en && bo == 2'd3) begin
            src = CMT_BYTE;
        end else if (flush && bo_next != 2'd0) begin
            src = CMT_FLUSH;
        end
        commit_valid = (src != CMT_NONE);
        // Staging is zeroed after every commit, so unwritten low lanes are already 0 for a flush.
        commit_data  = (src == CMT_LONG) ? long_data : packed_word;
    end

    // Staging register, byte offset and the rejected-longword pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            bo      <= 2'd0;
            err     <= 1'b0;
        end else if (clr) begin
            staging <= '0;
            bo      <= 2'd0;
            err     <= 1'b0;
        end else begin
            err <= wr_long && (bo != 2'd0);
            if (commit_valid) begin
                // Offset returns to 0 whether or not the FIFO accepts the entry.
                staging <= '0;
                bo      <= 2'd0;
            end else if (byte_en) begin
                staging <= packed_word;
                bo      <= bo_next;
            end
        end
    end

endmodule

// File: rtl/sdmac_fifo_packer.sv
// Longword FIFO feeding the CPU-side output datapath; head entry drives OD.
module sdmac_fifo_packer
    import sdmac_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          SCLK,
    input  logic          _RST,
    input  logic          FIFO_CLR,
    input  logic          WR_BYTE,
    input  logic [7:0]    BYTE_IN,
    input  logic          WR_LONG,
    input  logic [31:0]   ID,
    input  logic          FLUSH,
    input  logic          RD_LONG,
    output logic [31:0]   OD,
    output logic          FIFOFULL,
    output logic          FIFOEMPTY,
    output logic [AW:0]   LEVEL,
    output logic [1:0]    BO,
    output logic          BOEQ3,
    output logic          OVF,
    output logic          UNF,
    output logic          ERR
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          commit_valid;
    logic [31:0]   commit_data;
    logic          accept;
    logic          pop;
    logic [AW:0]   level_next;

    sdmac_byte_packer u_packer (
        .clk          (SCLK),
        .rst_n        (_RST),
        .clr          (FIFO_CLR),
        .wr_byte      (WR_BYTE),
        .byte_data    (BYTE_IN),
        .wr_long      (WR_LONG),
        .long_data    (ID),
        .flush        (FLUSH),
        .bo           (BO),
        .err          (ERR),
        .commit_valid (commit_valid),
        .commit_data  (commit_data)
    );

    // A full FIFO still takes a commit when the head is popped in the same cycle.
    always_comb begin
        accept     = commit_valid && (!FIFOFULL || RD_LONG);
        pop        = RD_LONG && !FIFOEMPTY;
        level_next = LEVEL;
        case ({accept, pop})
            2'b10:   level_next = LEVEL + 1'b1;
            2'b01:   level_next = LEVEL - 1'b1;
            default: level_next = LEVEL;
        endcase
    end

    // Entry storage is never cleared; emptiness gates what OD shows.
    always_ff @(posedge SCLK) begin
        if (accept && !FIFO_CLR) begin
            mem[wptr] <= commit_data;
        end
    end

    // Pointers, occupancy, status and sticky error flags.
    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            wptr      <= '0;
            rptr      <= '0;
            LEVEL     <= '0;
            FIFOFULL  <= 1'b0;
            FIFOEMPTY <= 1'b1;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else if (FIFO_CLR) begin
            wptr      <= '0;
            rptr      <= '0;
            LEVEL     <= '0;
            FIFOFULL  <= 1'b0;
            FIFOEMPTY <= 1'b1;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            LEVEL     <= level_next;
            FIFOFULL  <= (level_next == LVL_FULL);
            FIFOEMPTY <= (level_next == '0);
            if (commit_valid && !accept) OVF <= 1'b1;
            if (RD_LONG && FIFOEMPTY)    UNF <= 1'b1;
        end
    end

    assign OD    = FIFOEMPTY ? 32'd0 : mem[rptr];
    assign BOEQ3 = (BO == 2'd3);

endmodule

// File: tb/tb_sdmac_fifo_packer.sv
// Bench for sdmac_fifo_packer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sdmac_fifo_packer;

    logic        SCLK = 1'b0;
    logic        _RST = 1'b0;
    logic        FIFO_CLR = 1'b0;
    logic        WR_BYTE = 1'b0;
    logic [7:0]  BYTE_IN = 8'd0;
    logic        WR_LONG = 1'b0;
    logic [31:0] ID = 32'd0;
    logic        FLUSH = 1'b0;
    logic        RD_LONG = 1'b0;
    logic [31:0] OD;
    logic        FIFOFULL;
    logic        FIFOEMPTY;
    logic [3:0]  LEVEL;
    logic [1:0]  BO;
    logic        BOEQ3;
    logic        OVF;
    logic        UNF;
    logic        ERR;

    sdmac_fifo_packer dut (
        .SCLK      (SCLK),
        ._RST      (_RST),
        .FIFO_CLR  (FIFO_CLR),
        .WR_BYTE   (WR_BYTE),
        .BYTE_IN   (BYTE_IN),
        .WR_LONG   (WR_LONG),
        .ID        (ID),
        .FLUSH     (FLUSH),
        .RD_LONG   (RD_LONG),
        .OD        (OD),
        .FIFOFULL  (FIFOFULL),
        .FIFOEMPTY (FIFOEMPTY),
        .LEVEL     (LEVEL),
        .BO        (BO),
        .BOEQ3     (BOEQ3),
        .OVF       (OVF),
        .UNF       (UNF),
        .ERR       (ERR)
    );

    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, partially packed bytes as a byte list.
    logic [31:0] mq[$];
    logic [7:0]  msb[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_err = 1'b0;

    function automatic logic [31:0] pack_bytes();
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < msb.size(); k++) begin
            w = w | ({24'd0, msb[k]} << (24 - 8 * k));
        end
        return w;
    endfunction

    task automatic model_clear();
        mq.delete();
        msb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic clr, input logic wb, input logic [7:0] b,
                              input logic wl, input logic [31:0] idv,
                              input logic fl, input logic rd);
        logic        c;
        logic [31:0] w;
        logic        was_empty;
        logic        was_full;
        if (clr) begin
            model_clear();
            return;
        end
        c = 1'b0;
        w = 32'd0;
        m_err = 1'b0;
        if (wl) begin
            if (msb.size() == 0) begin
                c = 1'b1;
                w = idv;
            end else begin
                m_err = 1'b1;
            end
        end else if (wb) begin
            msb.push_back(b);
            if (msb.size() == 4) begin
                c = 1'b1;
                w = pack_bytes();
                msb.delete();
            end
        end
        if (fl && !c && msb.size() != 0) begin
            c = 1'b1;
            w = pack_bytes();
            msb.delete();
        end
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == 8);
        if (rd && was_empty) m_unf = 1'b1;
        if (rd && !was_empty) mq.delete(0);
        if (c) begin
            if (!was_full || rd) mq.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] exp_od;
        exp_od = (mq.size() != 0) ? mq[0] : 32'd0;
        check({tag, "_level"}, 32'(LEVEL), 32'(mq.size()));
        check({tag, "_bo"},    32'(BO),    32'(msb.size()));
        check({tag, "_od"},    OD,         exp_od);
        check({tag, "_full"},  32'(FIFOFULL),  32'(mq.size() == 8));
        check({tag, "_empty"}, 32'(FIFOEMPTY), 32'(mq.size() == 0));
        check({tag, "_boeq3"}, 32'(BOEQ3), 32'(msb.size() == 3));
        check({tag, "_ovf"},   32'(OVF),   32'(m_ovf));
        check({tag, "_unf"},   32'(UNF),   32'(m_unf));
        check({tag, "_err"},   32'(ERR),   32'(m_err));
    endtask

    // One clock: drive inputs, step the model, sample 1 time unit after the edge.
    task automatic apply(input string tag, input logic clr, input logic wb, input logic [7:0] b,
                         input logic wl, input logic [31:0] idv, input logic fl, input logic rd);
        FIFO_CLR = clr;
        WR_BYTE  = wb;
        BYTE_IN  = b;
        WR_LONG  = wl;
        ID       = idv;
        FLUSH    = fl;
        RD_LONG  = rd;
        model_step(clr, wb, b, wl, idv, fl, rd);
        @(posedge SCLK);
        #1;
        compare_model(tag);
        FIFO_CLR = 1'b0;
        WR_BYTE  = 1'b0;
        BYTE_IN  = 8'd0;
        WR_LONG  = 1'b0;
        ID       = 32'd0;
        FLUSH    = 1'b0;
        RD_LONG  = 1'b0;
    endtask

    typedef struct {
        logic        clr;
        logic        wb;
        logic [7:0]  b;
        logic        wl;
        logic [31:0] id;
        logic        fl;
        logic        rd;
        logic [3:0]  e_level;
        logic [1:0]  e_bo;
        logic [31:0] e_od;
        logic        e_empty;
        logic        e_ovf;
        logic        e_unf;
        logic        e_err;
    } vec_t;

    function automatic vec_t v(input logic clr, input logic wb, input logic [7:0] b,
                               input logic wl, input logic [31:0] id, input logic fl,
                               input logic rd, input logic [3:0] lvl, input logic [1:0] bo,
                               input logic [31:0] od, input logic em, input logic ov,
                               input logic un, input logic er);
        vec_t r;
        r.clr = clr; r.wb = wb; r.b = b; r.wl = wl; r.id = id; r.fl = fl; r.rd = rd;
        r.e_level = lvl; r.e_bo = bo; r.e_od = od; r.e_empty = em;
        r.e_ovf = ov; r.e_unf = un; r.e_err = er;
        return r;
    endfunction

    vec_t vt[$];

    initial begin
        //             clr wb b      wl id            fl rd  lvl bo od            em ov un er
        vt.push_back(v(0, 1, 8'h11, 0, 32'd0,        0, 0, 0, 1, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h22, 0, 32'd0,        0, 0, 0, 2, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h33, 0, 32'd0,        0, 0, 0, 3, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h44, 0, 32'd0,        0, 0, 1, 0, 32'h11223344, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 0, 0, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'hAA, 0, 32'd0,        0, 0, 0, 1, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'hBB, 0, 32'd0,        0, 0, 0, 2, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        1, 0, 1, 0, 32'hAABB0000, 0, 0, 0, 0));
        vt.push_back(v(0, 1, 8'hCC, 0, 32'd0,        0, 0, 1, 1, 32'hAABB0000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 1, 32'hDEADBEEF, 0, 0, 1, 1, 32'hAABB0000, 0, 0, 0, 1));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 0, 1, 1, 32'hAABB0000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        1, 0, 2, 0, 32'hAABB0000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 1, 0, 32'hCC000000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 0, 0, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 0, 0, 32'h0,        1, 0, 1, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 0, 0, 0, 32'h0,        1, 0, 1, 0));
        vt.push_back(v(1, 0, 8'h00, 0, 32'd0,        0, 0, 0, 0, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h01, 0, 32'd0,        0, 0, 0, 1, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h02, 0, 32'd0,        1, 0, 1, 0, 32'h01020000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        1, 0, 1, 0, 32'h01020000, 0, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h03, 1, 32'h12345678, 0, 0, 2, 0, 32'h01020000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 1, 0, 32'h12345678, 0, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h55, 0, 32'd0,        0, 0, 1, 1, 32'h12345678, 0, 0, 0, 0));
        vt.push_back(v(1, 1, 8'h66, 0, 32'd0,        0, 1, 0, 0, 32'h0,        1, 0, 0, 0));
        vt.push_back(v(0, 1, 8'h77, 0, 32'd0,        1, 0, 1, 0, 32'h77000000, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 8'h00, 0, 32'd0,        0, 1, 0, 0, 32'h0,        1, 0, 0, 0));

        // Reset state
        model_clear();
        repeat (2) @(posedge SCLK);
        #1;
        compare_model("rst");
        check("rst_od_zero", OD, 32'd0);
        _RST = 1'b1;

        // Directed vector table
        for (int i = 0; i < vt.size(); i++) begin
            string tg;
            tg = $sformatf("v%0d", i);
            apply(tg, vt[i].clr, vt[i].wb, vt[i].b, vt[i].wl, vt[i].id, vt[i].fl, vt[i].rd);
            check({tg, "_lvl_k"},   32'(LEVEL),     32'(vt[i].e_level));
            check({tg, "_bo_k"},    32'(BO),        32'(vt[i].e_bo));
            check({tg, "_od_k"},    OD,             vt[i].e_od);
            check({tg, "_empty_k"}, 32'(FIFOEMPTY), 32'(vt[i].e_empty));
            check({tg, "_ovf_k"},   32'(OVF),       32'(vt[i].e_ovf));
            check({tg, "_unf_k"},   32'(UNF),       32'(vt[i].e_unf));
            check({tg, "_err_k"},   32'(ERR),       32'(vt[i].e_err));
        end

        // Fill to full, overflow, then simultaneous pop and commit while full
        apply("t2clr", 1, 0, 8'h00, 0, 32'd0, 0, 0);
        for (int i = 0; i < 8; i++) apply("t2w", 0, 0, 8'h00, 1, 32'hA0000000 + 32'(i), 0, 0);
        check("t2_full", 32'(FIFOFULL), 32'd1);
        check("t2_level8", 32'(LEVEL), 32'd8);
        apply("t2ovf", 0, 0, 8'h00, 1, 32'hA0000008, 0, 0);
        check("t2_ovf", 32'(OVF), 32'd1);
        check("t2_ovf_level", 32'(LEVEL), 32'd8);
        check("t2_ovf_od", OD, 32'hA0000000);
        apply("t2rw", 0, 0, 8'h00, 1, 32'hA0000009, 0, 1);
        check("t2_rw_level", 32'(LEVEL), 32'd8);
        check("t2_rw_od", OD, 32'hA0000001);
        check("t2_rw_full", 32'(FIFOFULL), 32'd1);

        // Pointer wrap: 3 in, 3 out, 8 in, 8 out in order
        apply("t5clr", 1, 0, 8'h00, 0, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++) apply("t5a", 0, 0, 8'h00, 1, 32'hC0000000 + 32'(i), 0, 0);
        for (int i = 0; i < 3; i++) apply("t5b", 0, 0, 8'h00, 0, 32'd0, 0, 1);
        for (int i = 0; i < 8; i++) apply("t5c", 0, 0, 8'h00, 1, 32'hD0000000 + 32'(i), 0, 0);
        check("t5_full", 32'(FIFOFULL), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_od%0d", i), OD, 32'hD0000000 + 32'(i));
            apply("t5d", 0, 0, 8'h00, 0, 32'd0, 0, 1);
            check($sformatf("t5_empty%0d", i), 32'(FIFOEMPTY), 32'(i == 7));
        end

        // Asynchronous reset mid-byte with entries held
        apply("t6clr", 1, 0, 8'h00, 0, 32'd0, 0, 0);
        for (int i = 0; i < 5; i++) apply("t6w", 0, 0, 8'h00, 1, 32'hE0000000 + 32'(i), 0, 0);
        apply("t6b", 0, 1, 8'h77, 0, 32'd0, 0, 0);
        apply("t6b", 0, 1, 8'h88, 0, 32'd0, 0, 0);
        check("t6_pre_bo", 32'(BO), 32'd2);
        check("t6_pre_level", 32'(LEVEL), 32'd5);
        #2;
        _RST = 1'b0;
        model_clear();
        #1;
        check("t6_level", 32'(LEVEL), 32'd0);
        check("t6_bo", 32'(BO), 32'd0);
        check("t6_empty", 32'(FIFOEMPTY), 32'd1);
        check("t6_od", OD, 32'd0);
        @(negedge SCLK);
        _RST = 1'b1;
        @(posedge SCLK);
        #1;
        apply("t6post", 0, 1, 8'h99, 0, 32'd0, 1, 0);
        check("t6_post_od", OD, 32'h99000000);
        apply("t6clr2", 1, 0, 8'h00, 0, 32'd0, 0, 0);

        // Randomized traffic with phases biased towards filling and draining
        for (int i = 0; i < 3000; i++) begin
            int ph;
            int rdp;
            ph  = (i / 200) % 3;
            rdp = (ph == 0) ? 15 : ((ph == 1) ? 45 : 80);
            apply("rnd",
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 45,
                  8'($urandom),
                  $urandom_range(0, 99) < 20,
                  $urandom,
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < rdp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
